// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe_stage_reg skid-buffered pipeline register:
// occupancy state encoding and default parameter widths.
package pipe_pkg;

    localparam int DATA_W_DEF = 96;
    localparam int ADDR_W_DEF = 32;
    localparam int CNT_W_DEF  = 32;

    // Number of payload words currently held by the stage.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the pipe_stage_reg statistics;
// sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (inc && !(&count)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffered pipeline register with flush/redirect and optional
// statistics counters (enabled by defining PIPE_STAGE_REG_STATS_EN).
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    input  logic [ADDR_W-1:0] redir_addr_in,
    output logic              redir_out,
    output logic [ADDR_W-1:0] redir_addr_out,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              in_hs;
    logic              out_hs;
    logic              load_main_in;
    logic              load_main_skid;
    logic              load_skid;

    // in_ready is a pure decode of the state flop, so no combinational
    // path exists from out_ready back to the upstream stage.
    assign out_valid = (state != EMPTY);
    assign in_ready  = (state != TWO);
    assign out_data  = main_q;

    assign in_hs  = in_valid & in_ready;
    assign out_hs = out_valid & out_ready;

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_hs) begin
                        state_nxt    = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (in_hs && !out_hs) begin
                        state_nxt = TWO;
                        load_skid = 1'b1;
                    end else if (in_hs && out_hs) begin
                        load_main_in = 1'b1;
                    end else if (out_hs) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    if (out_hs) begin
                        state_nxt      = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples values from before the edge regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: the payload registers are reset as well, so a reset leaves no stale
    // word visible on out_data.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in) begin
                main_q <= in_data;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            redir_out      <= 1'b0;
            redir_addr_out <= '0;
        end else begin
            redir_out <= flush;
            if (flush) begin
                redir_addr_out <= redir_addr_in;
            end
        end
    end

`ifdef PIPE_STAGE_REG_STATS_EN
    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (out_valid & ~out_ready),
        .count  (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (flush),
        .count  (flush_cnt)
    );
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: a queue model of the two-entry buffer
// is fed by the driver, and a negedge monitor pops and compares.
module tb_pipe_stage_reg;

    localparam int DW = 96;
    localparam int AW = 32;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          flush = 1'b0;
    logic [AW-1:0] redir_addr_in = '0;
    logic          redir_out;
    logic [AW-1:0] redir_addr_out;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;

    // Second instance with a 2-bit counter to observe saturation.
    logic          s_in_ready;
    logic          s_out_valid;
    logic [DW-1:0] s_out_data;
    logic          s_redir_out;
    logic [AW-1:0] s_redir_addr_out;
    logic [1:0]    s_stall_cnt;
    logic [1:0]    s_flush_cnt;

    always #5 clk = ~clk;

    pipe_stage_reg u_dut (
        .clk            (clk),
        .resetn         (resetn),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .flush          (flush),
        .redir_addr_in  (redir_addr_in),
        .redir_out      (redir_out),
        .redir_addr_out (redir_addr_out),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    pipe_stage_reg #(.CNT_W(2)) u_small (
        .clk            (clk),
        .resetn         (resetn),
        .in_valid       (in_valid),
        .in_ready       (s_in_ready),
        .in_data        (in_data),
        .out_valid      (s_out_valid),
        .out_ready      (out_ready),
        .out_data       (s_out_data),
        .flush          (flush),
        .redir_addr_in  (redir_addr_in),
        .redir_out      (s_redir_out),
        .redir_addr_out (s_redir_addr_out),
        .stall_cnt      (s_stall_cnt),
        .flush_cnt      (s_flush_cnt)
    );

    int            vectors = 0;
    int            miscompares = 0;
    logic [DW-1:0] sb[$];
    int            occ = 0;
    int            stalls = 0;
    int            flushes = 0;
    logic          prev_fl = 1'b0;
    logic [AW-1:0] exp_addr = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: called at posedge+1, drives inputs, updates the model,
    // returns at the next posedge+1.
    task automatic step(input logic iv, input logic [DW-1:0] d, input logic ordy,
                        input logic fl, input logic [AW-1:0] ad);
        bit acc;
        bit pop;
        in_valid      = iv;
        in_data       = d;
        out_ready     = ordy;
        flush         = fl;
        redir_addr_in = ad;
        acc = iv && (occ < 2) && !fl;
        pop = (occ > 0) && ordy;
        if (acc) sb.push_back(d);
        if (occ > 0 && !ordy) stalls++;
        if (fl) flushes++;
        @(posedge clk);
        #1;
        occ = fl ? 0 : occ + int'(acc) - int'(pop);
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, '0, ordy, 1'b0, '0);
    endtask

    task automatic check_stats(input string tag);
`ifdef PIPE_STAGE_REG_STATS_EN
        check({tag, "_stall_cnt"}, stall_cnt, stalls);
        check({tag, "_flush_cnt"}, flush_cnt, flushes);
        check({tag, "_small_stall_cnt"}, s_stall_cnt, (stalls > 3) ? 3 : stalls);
`else
        check({tag, "_stall_cnt"}, stall_cnt, 0);
        check({tag, "_flush_cnt"}, flush_cnt, 0);
        check({tag, "_small_stall_cnt"}, s_stall_cnt, 0);
`endif
    endtask

    // Monitor: compares against the model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!resetn) begin
                prev_fl  = 1'b0;
                exp_addr = '0;
            end else begin
                check("out_valid", out_valid, occ != 0);
                check("in_ready", in_ready, occ != 2);
                if (out_valid) begin
                    if (sb.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL out_data: got %h, expected no valid word at %0t", out_data, $time);
                    end else begin
                        check("out_data", out_data, sb[0]);
                        if (out_ready) void'(sb.pop_front());
                    end
                end
                check("redir_out", redir_out, prev_fl);
                check("redir_addr_out", redir_addr_out, exp_addr);
                prev_fl = flush;
                if (flush) begin
                    exp_addr = redir_addr_in;
                    sb.delete();
                end
            end
        end
    end

    initial begin
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_redir_out", redir_out, 0);
        check("rst_redir_addr", redir_addr_out, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;

        // Statistics: 5 stall cycles then 2 flushes.
        step(1'b1, 96'hC0, 1'b0, 1'b0, '0);
        repeat (5) idle(1'b0);
        step(1'b0, '0, 1'b1, 1'b1, 32'h10);
        step(1'b0, '0, 1'b1, 1'b1, 32'h20);
        idle(1'b1);
`ifdef PIPE_STAGE_REG_STATS_EN
        check("stats5_stall_cnt", stall_cnt, 5);
        check("stats5_flush_cnt", flush_cnt, 2);
        check("stats5_small_stall_cnt", s_stall_cnt, 3);
`else
        check("stats5_stall_cnt", stall_cnt, 0);
        check("stats5_flush_cnt", flush_cnt, 0);
        check("stats5_small_stall_cnt", s_stall_cnt, 0);
`endif

        // Streaming with out_ready high: one word per cycle, one-cycle latency.
        step(1'b1, 96'hA1, 1'b1, 1'b0, '0);
        check("lat_a1", out_data, 96'hA1);
        step(1'b1, 96'hA2, 1'b1, 1'b0, '0);
        check("lat_a2", out_data, 96'hA2);
        step(1'b1, 96'hA3, 1'b1, 1'b0, '0);
        check("lat_a3", out_data, 96'hA3);
        idle(1'b1);

        // Backpressure: two accepted, third held off, then drained in order.
        step(1'b1, 96'hB1, 1'b0, 1'b0, '0);
        step(1'b1, 96'hB2, 1'b0, 1'b0, '0);
        step(1'b1, 96'hB3, 1'b0, 1'b0, '0);
        check("bp_in_ready_low", in_ready, 0);
        check("bp_hold_b1", out_data, 96'hB1);
        step(1'b1, 96'hB3, 1'b1, 1'b0, '0);
        step(1'b1, 96'hB3, 1'b1, 1'b0, '0);
        repeat (3) idle(1'b1);

        // Flush from TWO with a redirect target.
        step(1'b1, 96'hD1, 1'b0, 1'b0, '0);
        step(1'b1, 96'hD2, 1'b0, 1'b0, '0);
        step(1'b0, '0, 1'b0, 1'b1, 32'h0000_0400);
        check("flush_out_valid", out_valid, 0);
        check("flush_redir_out", redir_out, 1);
        check("flush_redir_addr", redir_addr_out, 32'h400);
        idle(1'b1);
        check("flush_redir_pulse", redir_out, 0);

        // Flush with in-handshake and out-handshake in the same cycle.
        step(1'b1, 96'hE1, 1'b1, 1'b0, '0);
        step(1'b1, 96'hE2, 1'b1, 1'b1, 32'h0000_0800);
        check("flush_drop_valid", out_valid, 0);
        idle(1'b1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, {$urandom(), $urandom(), $urandom()},
                 $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, $urandom());
        end
        check_stats("rand");

        // Asynchronous reset in the middle of a stall.
        step(1'b1, 96'hF1, 1'b0, 1'b0, '0);
        step(1'b1, 96'hF2, 1'b0, 1'b1, 32'h0000_0C00);
        step(1'b1, 96'hF3, 1'b0, 1'b0, '0);
        step(1'b1, 96'hF4, 1'b0, 1'b0, '0);
        idle(1'b0);
        in_valid = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        check("areset_out_valid", out_valid, 0);
        check("areset_in_ready", in_ready, 1);
        check("areset_redir_addr", redir_addr_out, 0);
        check("areset_out_data", out_data, 0);
        check("areset_stall_cnt", stall_cnt, 0);
        occ = 0;
        sb.delete();
        stalls = 0;
        flushes = 0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        step(1'b1, 96'h1234, 1'b0, 1'b0, '0);
        check("post_reset_accept", out_data, 96'h1234);
        for (int i = 0; i < 100; i++) begin
            step($urandom_range(0, 1) != 0, {$urandom(), $urandom(), $urandom()},
                 $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0, $urandom());
        end
        idle(1'b1);
        check_stats("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
